// File: rtl/load_writeback_unit.sv
// load_writeback_unit: issues a word-aligned memory read for a RISC-V load and writes the extracted, extended value to the register file.
// Optional LOAD_TIMEOUT_EN aborts a load whose response has not arrived within TIMEOUT_CYCLES cycles in WAIT.
module load_writeback_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [31:0] addr,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        load_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;
    state_t state, state_nx;
    logic [2:0]  f3;
    logic [31:0] a;
    logic        bad, err_nx, timeout;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext;

    assign bad = funct3 == 3'b011 || funct3[2:1] == 2'b11
              || (funct3[1:0] == 2'b01 && addr[0])
              || (funct3 == 3'b010 && addr[1:0] != 2'b00);
    assign byte_sel = a[1] ? (a[0] ? mem_rsp_data[31:24] : mem_rsp_data[23:16])
                           : (a[0] ? mem_rsp_data[15:8] : mem_rsp_data[7:0]);
    assign half_sel = a[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    // f3[2] selects zero-extension for LBU/LHU
    assign ext = f3[1] ? mem_rsp_data
               : f3[0] ? {{16{~f3[2] & half_sel[15]}}, half_sel}
               : {{24{~f3[2] & byte_sel[7]}}, byte_sel};

`ifdef LOAD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign timeout = state == WAIT && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else        cnt <= state == WAIT ? cnt + 1'b1 : '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (bad) err_nx = 1'b1;
                else     state_nx = REQ;
            end
            REQ:  if (mem_req_ready) state_nx = WAIT;
            WAIT: if (mem_rsp_valid) state_nx = WB;
                  else if (timeout) begin
                      state_nx = IDLE;
                      err_nx   = 1'b1;
                  end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            f3         <= '0;
            a          <= '0;
            write_reg  <= '0;
            write_data <= '0;
            load_err   <= 1'b0;
        end else begin
            state    <= state_nx;
            load_err <= err_nx;
            if (state == IDLE && state_nx == REQ) begin
                f3        <= funct3;
                a         <= addr;
                write_reg <= rd;
            end
            if (state == WAIT && mem_rsp_valid) write_data <= ext;
        end
    end

    assign busy          = state != IDLE;
    assign mem_req_valid = state == REQ;
    assign mem_req_addr  = {a[31:2], 2'b00};
    assign reg_write     = state == WB && write_reg != 5'd0;
endmodule

// File: tb/tb_load_writeback_unit.sv
// tb_load_writeback_unit: randomized and directed loads checked by a scoreboard against a reference model.
module tb_load_writeback_unit;
`ifdef LOAD_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    logic        clk = 0, reset = 0, start = 0, mem_req_ready = 0, mem_rsp_valid = 0;
    logic [2:0]  funct3 = 0;
    logic [4:0]  rd = 0;
    logic [31:0] addr = 0, mem_rsp_data = 0;
    logic        mem_req_valid, reg_write, busy, load_err;
    logic [31:0] mem_req_addr, write_data;
    logic [4:0]  write_reg;

    load_writeback_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3), .rd(rd), .addr(addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .busy(busy), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {bit is_err; logic [4:0] r; logic [31:0] d;} exp_t;
    exp_t sb[$];
    int vectors = 0, miscompares = 0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [2:0] f, input logic [31:0] a);
        return (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && (a % (32'd1 << f[1:0]) == 0);
    endfunction

    function automatic logic [31:0] ref_data(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = w >> (8 * a[1:0]);
        h = w >> (16 * a[1]);
        case (f)
            3'd0:    return {{24{b[7]}}, b[7:0]};
            3'd1:    return {{16{h[15]}}, h[15:0]};
            3'd4:    return {24'd0, b[7:0]};
            3'd5:    return {16'd0, h[15:0]};
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset && (reg_write || load_err)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_event: reg_write=%b load_err=%b write_reg=%0d expected none", reg_write, load_err, write_reg);
            end else begin
                e = sb.pop_front();
                chk("event_is_err", load_err, e.is_err);
                if (!e.is_err) begin
                    chk("write_reg", write_reg, e.r);
                    chk("write_data", write_data, e.d);
                end
            end
        end
    end

    task automatic do_load(input logic [2:0] f, input logic [4:0] r, input logic [31:0] a, input logic [31:0] w,
                           input int rdly, input int wdly);
        bit ok = legal(f, a);
        if (!ok) sb.push_back('{is_err: 1'b1, r: 5'd0, d: 32'd0});
        else if (r != 0) sb.push_back('{is_err: 1'b0, r: r, d: ref_data(f, a, w)});
        @(posedge clk); #1;
        start = 1; funct3 = f; rd = r; addr = a;
        @(posedge clk); #1;
        start = 0; funct3 = 3'($urandom); rd = 5'($urandom); addr = $urandom;
        if (!ok) begin
            @(negedge clk);
            chk("err_busy", busy, 0);
            chk("err_req_valid", mem_req_valid, 0);
            chk("err_reg_write", reg_write, 0);
            return;
        end
        for (int i = 0; i <= rdly; i++) begin
            mem_req_ready = (i == rdly); mem_rsp_valid = 1'($urandom); mem_rsp_data = $urandom;
            @(negedge clk);
            chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_req_addr, {a[31:2], 2'b00});
            @(posedge clk); #1;
        end
        mem_req_ready = 0;
        for (int j = 0; j <= wdly; j++) begin
            mem_rsp_valid = (j == wdly); mem_rsp_data = (j == wdly) ? w : $urandom;
            @(negedge clk);
            chk("wait_busy", busy, 1);
            chk("wait_req_valid", mem_req_valid, 0);
            chk("wait_reg_write", reg_write, 0);
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'($urandom); mem_rsp_data = $urandom;
        @(negedge clk);
        chk("wb_reg_write", reg_write, r != 0);
        chk("wb_busy", busy, 1);
        @(posedge clk); #1;
        mem_rsp_valid = 0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_write_reg", write_reg, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_load_err", load_err, 0);
    endtask

    initial begin
        #3 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 reset = 1;
        do_load(3'd0, 5'd1, 32'h0000_1003, 32'h80FF_FF12, 0, 0);
        do_load(3'd5, 5'd5, 32'h0000_2002, 32'h8001_1234, 0, 0);
        do_load(3'd2, 5'd4, 32'h0000_3001, 32'h1234_5678, 0, 0);
        do_load(3'd2, 5'd0, 32'h0000_4000, 32'hDEAD_BEEF, 0, 0);
        do_load(3'd3, 5'd9, 32'h0000_0000, 32'h0, 0, 0);
        do_load(3'd1, 5'd9, 32'h0000_0001, 32'h0, 0, 0);
        do_load(3'd4, 5'd31, 32'h0000_0002, 32'h00F0_0000, 2, 3);
        // reset while a load sits in WAIT must drop it without a later write
        @(posedge clk); #1;
        start = 1; funct3 = 3'd2; rd = 5'd7; addr = 32'h4000_0010;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_req_valid", mem_req_valid, 1);
            chk("stall_req_addr", mem_req_addr, 32'h4000_0010);
            @(posedge clk); #1;
        end
        mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0;
        #2 reset = 0;
        #1 check_reset_outputs();
        @(posedge clk); #1;
        reset = 1; mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1 mem_rsp_valid = 0;
        @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_write", reg_write, 0);
        for (int k = 0; k < 40; k++) begin
            logic [2:0] f;
            logic [4:0] r;
            f = 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            do_load(f, r, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end
`ifdef LOAD_TIMEOUT_EN
        sb.push_back('{is_err: 1'b1, r: 5'd0, d: 32'd0});
        @(posedge clk); #1;
        start = 1; funct3 = 3'd2; rd = 5'd3; addr = 32'h0000_5000;
        @(posedge clk); #1;
        start = 0; mem_req_ready = 1;
        @(posedge clk); #1;
        mem_req_ready = 0;
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            chk("to_wait_busy", busy, 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_busy", busy, 0);
        chk("to_load_err", load_err, 1);
        chk("to_reg_write", reg_write, 0);
`endif
        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
